// File: rtl/retire_reclaim_unit.sv
// Commit-side companion to rename: holds the retirement RAT, returns superseded
// physical registers to the free list, and replays the committed map on flush.
module retire_reclaim_unit #(
    parameter int NUM_A_REGS = 32,
    parameter int NUM_P_REGS = 48,
    parameter int ARN_W      = 5,
    parameter int PRN_W      = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ret_valid,
    output logic             ret_ready,
    input  logic             ret_has_dest,
    input  logic [ARN_W-1:0] ret_arn,
    input  logic [PRN_W-1:0] ret_new_prn,
    input  logic [PRN_W-1:0] ret_old_prn,
    output logic             free_valid,
    input  logic             free_ready,
    output logic [PRN_W-1:0] free_prn,
    input  logic             flush_req,
    output logic             rst_valid,
    output logic [ARN_W-1:0] rst_arn,
    output logic [PRN_W-1:0] rst_prn,
    output logic             restore_busy,
    output logic             restore_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ARN_W-1:0] LAST_ARN  = ARN_W'(NUM_A_REGS - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    if (NUM_P_REGS > (1 << PRN_W)) begin : g_bad_prn_w
        $error("PRN_W too narrow for NUM_P_REGS");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2, at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WALK,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [ARN_W-1:0] idx_q, idx_d;
    logic [PRN_W-1:0] rrat_q [NUM_A_REGS];
    logic [PRN_W-1:0] rrat_d [NUM_A_REGS];
    logic [PRN_W-1:0] fifo_q [FIFO_DEPTH];
    logic [PRN_W-1:0] fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push;
    logic pop;

    // Readiness depends only on registered state, never on free_ready.
    assign ret_ready    = (state_q == S_IDLE) && (count_q < DEPTH_CNT);
    assign push         = ret_valid && ret_ready && ret_has_dest;
    assign free_valid   = (count_q != '0);
    assign free_prn     = fifo_q[head_q];
    assign pop          = free_valid && free_ready;

    assign rst_valid    = (state_q == S_WALK);
    assign rst_arn      = rst_valid ? idx_q : '0;
    assign rst_prn      = rst_valid ? rrat_q[idx_q] : '0;
    assign restore_busy = (state_q != S_IDLE);
    assign restore_done = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (flush_req) begin
                    state_d = S_WALK;
                    idx_d   = '0;
                end
            end
            S_WALK: begin
                if (idx_q == LAST_ARN) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A retire in the same cycle as flush_req lands in rrat before the walk reads it.
    always_comb begin
        rrat_d  = rrat_q;
        fifo_d  = fifo_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            rrat_d[ret_arn] = ret_new_prn;
            fifo_d[tail_q]  = ret_old_prn;
            tail_d          = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < NUM_A_REGS; i++) begin
                rrat_q[i] <= PRN_W'(i);
            end
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                fifo_q[j] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rrat_q  <= rrat_d;
            fifo_q  <= fifo_d;
        end
    end

endmodule

// File: tb/tb_retire_reclaim_unit.sv
// Bench for retire_reclaim_unit: directed scenarios plus random traffic, checked
// every cycle against a queue/array model of committed state and walk timeline.
module tb_retire_reclaim_unit;

    localparam int NA = 32;
    localparam int NP = 48;
    localparam int AW = 5;
    localparam int PW = 6;
    localparam int FD = 4;

    logic          clk;
    logic          rst;
    logic          ret_valid;
    logic          ret_ready;
    logic          ret_has_dest;
    logic [AW-1:0] ret_arn;
    logic [PW-1:0] ret_new_prn;
    logic [PW-1:0] ret_old_prn;
    logic          free_valid;
    logic          free_ready;
    logic [PW-1:0] free_prn;
    logic          flush_req;
    logic          rst_valid;
    logic [AW-1:0] rst_arn;
    logic [PW-1:0] rst_prn;
    logic          restore_busy;
    logic          restore_done;

    retire_reclaim_unit #(
        .NUM_A_REGS(NA), .NUM_P_REGS(NP), .ARN_W(AW), .PRN_W(PW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst),
        .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_has_dest(ret_has_dest),
        .ret_arn(ret_arn), .ret_new_prn(ret_new_prn), .ret_old_prn(ret_old_prn),
        .free_valid(free_valid), .free_ready(free_ready), .free_prn(free_prn),
        .flush_req(flush_req),
        .rst_valid(rst_valid), .rst_arn(rst_arn), .rst_prn(rst_prn),
        .restore_busy(restore_busy), .restore_done(restore_done)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: committed map, pending frees in retire order, and cycles since the
    // flush was taken (-1 = idle; 1..NA = walk entry t-1; NA+1 = done cycle).
    int m_rrat [NA];
    int m_q [$];
    int m_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NA; i++) m_rrat[i] = i;
        m_q.delete();
        m_t = -1;
    endtask

    initial begin
        bit idle, acc, pop;
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_reset();
            end else begin
                idle = (m_t < 0);
                acc  = ret_valid && idle && (m_q.size() < FD);
                pop  = (m_q.size() > 0) && free_ready;
                if (pop) void'(m_q.pop_front());
                if (acc && ret_has_dest) begin
                    m_q.push_back(int'(ret_old_prn));
                    m_rrat[ret_arn] = int'(ret_new_prn);
                end
                if (m_t >= 0) begin
                    m_t++;
                    if (m_t > NA + 1) m_t = -1;
                end else if (flush_req) begin
                    m_t = 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("m_ret_ready", int'(ret_ready), int'((m_t < 0) && (m_q.size() < FD)));
            chk("m_free_valid", int'(free_valid), int'(m_q.size() != 0));
            if (m_q.size() != 0) chk("m_free_prn", int'(free_prn), m_q[0]);
            chk("m_rst_valid", int'(rst_valid), int'((m_t >= 1) && (m_t <= NA)));
            if ((m_t >= 1) && (m_t <= NA)) begin
                chk("m_rst_arn", int'(rst_arn), m_t - 1);
                chk("m_rst_prn", int'(rst_prn), m_rrat[m_t-1]);
            end
            chk("m_busy", int'(restore_busy), int'(m_t >= 1));
            chk("m_done", int'(restore_done), int'(m_t == NA + 1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input int dest, input int arn, input int nw, input int old);
        ret_valid    = 1'b1;
        ret_has_dest = dest[0];
        ret_arn      = AW'(arn);
        ret_new_prn  = PW'(nw);
        ret_old_prn  = PW'(old);
        step();
        ret_valid    = 1'b0;
    endtask

    // Takes a flush this cycle (together with any retire already driven) and
    // follows the walk; optionally pins one entry, pulses flush mid-walk, or
    // stops early at abort_at leaving the DUT mid-walk.
    task automatic do_walk(input bit ident, input int pin_arn, input int pin_prn,
                           input int pulse_at, input int abort_at);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        ret_valid = 1'b0;
        for (int k = 0; k < NA; k++) begin
            if (k == abort_at) return;
            chk("walk_valid", int'(rst_valid), 1);
            chk("walk_arn", int'(rst_arn), k);
            chk("walk_ret_ready", int'(ret_ready), 0);
            if (ident) chk("walk_ident_prn", int'(rst_prn), k);
            if (k == pin_arn) chk("walk_pinned_prn", int'(rst_prn), pin_prn);
            if (k == pulse_at) flush_req = 1'b1;
            step();
            flush_req = 1'b0;
        end
        chk("walk_done_pulse", int'(restore_done), 1);
        chk("walk_done_busy", int'(restore_busy), 1);
        chk("walk_done_valid", int'(rst_valid), 0);
        step();
        chk("walk_after_busy", int'(restore_busy), 0);
        chk("walk_after_done", int'(restore_done), 0);
        chk("walk_after_ready", int'(ret_ready), 1);
    endtask

    initial begin
        rst = 1'b1;
        ret_valid = 1'b0; ret_has_dest = 1'b0; ret_arn = '0;
        ret_new_prn = '0; ret_old_prn = '0; free_ready = 1'b0; flush_req = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_ret_ready", int'(ret_ready), 1);
        chk("rst_free_valid", int'(free_valid), 0);
        chk("rst_free_prn", int'(free_prn), 0);
        chk("rst_rst_valid", int'(rst_valid), 0);
        chk("rst_rst_arn", int'(rst_arn), 0);
        chk("rst_rst_prn", int'(rst_prn), 0);
        chk("rst_busy", int'(restore_busy), 0);
        chk("rst_done", int'(restore_done), 0);
        repeat (5) step();
        chk("idle_ret_ready", int'(ret_ready), 1);
        chk("idle_free_valid", int'(free_valid), 0);
        chk("idle_busy", int'(restore_busy), 0);
        do_walk(1'b1, -1, 0, -1, -1);

        free_ready = 1'b1;
        retire(1, 3, 32, 3);
        chk("t2_free_valid", int'(free_valid), 1);
        chk("t2_free_prn", int'(free_prn), 3);
        step();
        chk("t2_popped", int'(free_valid), 0);
        do_walk(1'b0, 3, 32, -1, -1);

        free_ready = 1'b0;
        for (int i = 0; i < 4; i++) retire(1, 8 + i, 36 + i, 40 + i);
        chk("t3_full_ready", int'(ret_ready), 0);
        chk("t3_head", int'(free_prn), 40);
        retire(1, 20, 47, 44);
        free_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_drain_valid", int'(free_valid), 1);
            chk("t3_drain_prn", int'(free_prn), 40 + i);
            step();
        end
        chk("t3_empty", int'(free_valid), 0);
        chk("t3_ready_back", int'(ret_ready), 1);

        free_ready = 1'b0;
        retire(1, 1, 33, 11);
        retire(1, 2, 34, 12);
        free_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ret_valid = 1'b1; ret_has_dest = 1'b1;
            ret_arn = AW'(16 + (i % 8)); ret_new_prn = PW'(20 + i); ret_old_prn = PW'(20 + i);
            chk("t4_valid", int'(free_valid), 1);
            chk("t4_head", int'(free_prn), (i < 2) ? (11 + i) : (18 + i));
            chk("t4_ready", int'(ret_ready), 1);
            step();
        end
        ret_valid = 1'b0;
        chk("t4_head_after", int'(free_prn), 28);
        step(); step();
        chk("t4_drained", int'(free_valid), 0);

        ret_valid = 1'b1; ret_has_dest = 1'b1; ret_arn = 5; ret_new_prn = 45; ret_old_prn = 5;
        do_walk(1'b0, 5, 45, 7, -1);
        step();
        chk("t5_freed_old", int'(free_valid), 0);

        do_walk(1'b0, -1, 0, -1, 10);
        rst = 1'b1;
        #1;
        chk("t6_valid", int'(rst_valid), 0);
        chk("t6_arn", int'(rst_arn), 0);
        chk("t6_prn", int'(rst_prn), 0);
        chk("t6_busy", int'(restore_busy), 0);
        chk("t6_done", int'(restore_done), 0);
        chk("t6_ready", int'(ret_ready), 1);
        step();
        rst = 1'b0;
        repeat (3) step();
        chk("t6_no_done", int'(restore_done), 0);
        do_walk(1'b1, -1, 0, -1, -1);

        for (int c = 0; c < 3000; c++) begin
            ret_valid    = ($urandom_range(0, 2) != 0);
            ret_has_dest = ($urandom_range(0, 3) != 0);
            ret_arn      = AW'($urandom_range(0, NA - 1));
            ret_new_prn  = PW'($urandom_range(0, NP - 1));
            ret_old_prn  = PW'($urandom_range(0, NP - 1));
            free_ready   = ($urandom_range(0, 2) != 0);
            flush_req    = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 599) == 0) begin
                #2 rst = 1'b1;
                step();
                rst = 1'b0;
            end else begin
                step();
            end
        end
        ret_valid = 1'b0; flush_req = 1'b0; free_ready = 1'b1;
        repeat (40) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/retire_reclaim_unit.md
Name: retire_reclaim_unit

Overview:
Commit-side counterpart of the rename stage.
- Consumes in-order retire events from the ROB and maintains the retirement RAT (committed arch->phys mapping).
- Returns each retired instruction's superseded physical register to the rename free list through a valid/ready push interface.
- On a pipeline flush, streams the committed mapping back to the front-end RAT, one entry per cycle.

Parameters:
NUM_A_REGS, 32, number of architectural registers
NUM_P_REGS, 48, number of physical registers
ARN_W, 5, architectural register index width
PRN_W, 6, physical register index width
FIFO_DEPTH, 4, reclaim buffer entries (power of 2)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous reset, active-high
ret_valid  in  1  ROB presents a retiring instruction
ret_ready  out  1  retire accepted this cycle when ret_valid && ret_ready
ret_has_dest  in  1  retiring instruction writes a register
ret_arn  in  ARN_W  destination architectural register
ret_new_prn  in  PRN_W  physical register allocated at rename
ret_old_prn  in  PRN_W  previous mapping, to be freed
free_valid  out  1  free_prn holds a register to push to the free list
free_ready  in  1  free list accepts the push
free_prn  out  PRN_W  physical register being returned
flush_req  in  1  single-cycle request to restore the front-end RAT
rst_valid  out  1  restore write valid; no backpressure
rst_arn  out  ARN_W  RAT index being restored
rst_prn  out  PRN_W  committed mapping for rst_arn
restore_busy  out  1  restore walk in progress
restore_done  out  1  one-cycle pulse after last restore write

Behaviour:
- Reset (async, immediate):
  - rrat[i] = i; reclaim FIFO empty; FSM = IDLE; walk index = 0.
  - Outputs: ret_ready=1, free_valid=0, free_prn=0, rst_valid=0, rst_arn=0, rst_prn=0, restore_busy=0, restore_done=0.
  - Reset mid-walk aborts the walk; no restore_done is issued.
- FSM states: IDLE, WALK, DONE.
  - IDLE -> WALK when flush_req=1.
  - WALK -> DONE after index NUM_A_REGS-1 is emitted.
  - DONE -> IDLE unconditionally.
  - flush_req is ignored outside IDLE.
- ret_ready = (state==IDLE) && (count < FIFO_DEPTH). It has no combinational dependence on free_ready.
- Accepted retire with ret_has_dest=1:
  - rrat[ret_arn] <= ret_new_prn.
  - ret_old_prn is enqueued at the tail.
- Accepted retire with ret_has_dest=0: no state change.
- Reclaim FIFO:
  - free_valid = (count != 0); free_prn = head entry; both registered state, no input-to-output combinational path.
  - Pop on free_valid && free_ready.
  - Push and pop in the same cycle leave count unchanged; pointers wrap modulo FIFO_DEPTH.
  - An entry enqueued into an empty FIFO appears on free_prn the next cycle.
  - Order is strictly retire order.
- FIFO behaviour across flush:
  - The FIFO drains in all states; committed frees survive a flush.
  - The walk does not touch the FIFO.
- Walk timing:
  - flush_req sampled at edge T; rst_valid=1 for cycles T+1..T+NUM_A_REGS.
  - rst_arn = index 0,1,...,NUM_A_REGS-1 ascending; rst_prn = rrat[rst_arn].
  - restore_busy=1 throughout WALK and DONE.
  - restore_done=1 only in DONE (cycle T+NUM_A_REGS+1).
- Simultaneous retire and flush_req in IDLE:
  - The retire is accepted, since ret_ready is high in IDLE.
  - Its rrat update is visible to the walk.
- Multiple retires to the same ret_arn in consecutive cycles: the last write wins. Each old_prn is enqueued separately.
- Free-list reconstruction for speculative allocations after a flush is the rename stage's responsibility, derived from the restore stream.

Test Plan:
- Reset, then idle 5 cycles -> ret_ready=1, free_valid=0, restore_busy=0; flush -> rst stream (0,0),(1,1)...(31,31), restore_done at T+33.
- Retire {dest=1, arn=3, new=32, old=3}, free_ready=1 -> free_prn=3 with free_valid=1 one cycle later; a later walk shows rst_arn=3 -> rst_prn=32.
- free_ready=0, retire old_prn 40,41,42,43 -> ret_ready drops after 4th accept; raise free_ready -> pops 40,41,42,43 in order, ret_ready returns.
- Push and pop in the same cycle with count=2 -> count stays 2; head/tail wrap correctly over 10 transactions.
- flush_req with ret_valid (arn=5, new=45) in the same IDLE cycle -> retire accepted, walk shows (5,45); flush_req pulses during WALK ignored; ret_ready=0 during WALK.
- Assert rst at walk index 10 -> outputs immediately at reset values, no restore_done; rrat back to identity.
